// File: rtl/seq_multiplier_pkg.sv
// Shared types for the iterative shift-add multiplier.
// The state encoding is fixed so that debug traces read the same across builds.
package seq_multiplier_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Iteration counter width: must hold the values 0 .. width.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_multiplier.sv
// Radix-2 shift-add multiplier with a fixed latency of WIDTH+1 cycles from accept to result.
// Operands are reduced to magnitudes on accept and the sign is reapplied in FIX.
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int unsigned WIDTH        = 8,
  parameter bit          FULL_PRODUCT = 1'b0,
  localparam int unsigned OUT_W       = FULL_PRODUCT ? 2 * WIDTH : WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out,
  output logic             ovf,
  output logic [1:0]       state_o
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);
  localparam int unsigned ACC_W = 2 * WIDTH;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never depends combinationally on ready on either side.

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               neg_q, neg_d;
  logic               signed_q, signed_d;
  logic [OUT_W-1:0]   out_q, out_d;
  logic               ovf_q, ovf_d;

  logic               load_en;
  logic               step_en;
  logic               fix_en;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [ACC_W-1:0]   prod;
  logic               hi_nonzero;
  logic               sign_ext_ok;
  logic               ovf_calc;

  // ---------------------------------------------------------------- state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (in_valid) state_d = ST_RUN;
      ST_RUN:  if (count_q == CNT_W'(WIDTH - 1)) state_d = ST_FIX;
      ST_FIX:  state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- FSM outputs
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    load_en   = 1'b0;
    step_en   = 1'b0;
    fix_en    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        load_en  = in_valid;
      end
      ST_RUN:  step_en   = 1'b1;
      ST_FIX:  fix_en    = 1'b1;
      ST_DONE: out_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------- datapath
  always_comb begin
    a_mag = (signed_mode && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
    b_mag = (signed_mode && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
    prod  = neg_q ? (~acc_q + ACC_W'(1)) : acc_q;

    // Signed truncation is lossless only if the dropped bits replicate bit WIDTH-1.
    hi_nonzero  = |prod[ACC_W-1:WIDTH];
    sign_ext_ok = (&prod[ACC_W-1:WIDTH-1]) | ~(|prod[ACC_W-1:WIDTH-1]);
    ovf_calc    = FULL_PRODUCT ? 1'b0 : (signed_q ? ~sign_ext_ok : hi_nonzero);
  end

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    count_d  = count_q;
    neg_d    = neg_q;
    signed_d = signed_q;
    out_d    = out_q;
    ovf_d    = ovf_q;

    if (load_en) begin
      mcand_d  = a_mag;
      mplier_d = b_mag;
      neg_d    = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
      signed_d = signed_mode;
      acc_d    = '0;
      count_d  = '0;
    end

    if (step_en) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + (ACC_W'(mcand_q) << count_q);
      end
      mplier_d = mplier_q >> 1;
      count_d  = count_q + CNT_W'(1);
    end

    if (fix_en) begin
      out_d = prod[OUT_W-1:0];
      ovf_d = ovf_calc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      neg_q    <= 1'b0;
      signed_q <= 1'b0;
      out_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      neg_q    <= neg_d;
      signed_q <= signed_d;
      out_q    <= out_d;
      ovf_q    <= ovf_d;
    end
  end

  assign out     = out_q;
  assign ovf     = ovf_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed and random checks of seq_multiplier in three configurations
// (W=8 truncated, W=8 full product, W=16 full product) against an arithmetic model.
module tb_seq_multiplier;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_checks = 0;
  int n_pass   = 0;

  // ------------------------------------------------------------ clock / reset
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no end expected end");
    $fatal(1, "watchdog");
  end

  // ------------------------------------------------------------ DUTs
  logic        iv8 = 1'b0, or8 = 1'b0, sm8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        ir8, ov8, ovf8, ir8f, ov8f, ovf8f;
  logic [7:0]  o8;
  logic [15:0] o8f;
  logic [1:0]  st8, st8f;

  logic        iv16 = 1'b0, or16 = 1'b0, sm16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        ir16, ov16, ovf16;
  logic [31:0] o16;
  logic [1:0]  st16;

  seq_multiplier #(.WIDTH(8), .FULL_PRODUCT(1'b0)) u8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .signed_mode(sm8), .out_valid(ov8), .out_ready(or8), .out(o8), .ovf(ovf8),
    .state_o(st8)
  );

  seq_multiplier #(.WIDTH(8), .FULL_PRODUCT(1'b1)) u8f (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8f), .a(a8), .b(b8),
    .signed_mode(sm8), .out_valid(ov8f), .out_ready(or8), .out(o8f), .ovf(ovf8f),
    .state_o(st8f)
  );

  seq_multiplier #(.WIDTH(16), .FULL_PRODUCT(1'b1)) u16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .signed_mode(sm16), .out_valid(ov16), .out_ready(or16), .out(o16), .ovf(ovf16),
    .state_o(st16)
  );

  // ------------------------------------------------------------ model
  // Result packed as {ovf, out zero-extended to 32 bits}.
  function automatic logic [32:0] model(input int w, input bit fp, input logic [15:0] a,
                                        input logic [15:0] b, input bit sm);
    longint sa, sb, p;
    int ow;
    logic [63:0] m;
    logic ov;
    sa = longint'(a) & ((longint'(1) << w) - 1);
    sb = longint'(b) & ((longint'(1) << w) - 1);
    if (sm && a[w-1]) sa = sa - (longint'(1) << w);
    if (sm && b[w-1]) sb = sb - (longint'(1) << w);
    p  = sa * sb;
    ow = fp ? 2 * w : w;
    m  = 64'(p) & ((64'(1) << ow) - 64'(1));
    if (fp) ov = 1'b0;
    else if (sm) ov = (p < -(longint'(1) << (w - 1))) || (p >= (longint'(1) << (w - 1)));
    else ov = (p >= (longint'(1) << w));
    return {ov, m[31:0]};
  endfunction

  // ------------------------------------------------------------ scoreboard
  logic [32:0] q8[$];
  logic [32:0] q8f[$];
  logic [32:0] q16[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  always @(negedge clk) begin
    if (!rst && ov8) begin
      if (q8.size() == 0) begin
        n_checks++;
        $display("FAIL u8 unexpected result: got %0h expected none", o8);
      end else begin
        chk("u8 result", 64'({ovf8, 32'(o8)}), 64'(q8[0]));
        if (or8) void'(q8.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && ov8f) begin
      if (q8f.size() == 0) begin
        n_checks++;
        $display("FAIL u8f unexpected result: got %0h expected none", o8f);
      end else begin
        chk("u8f result", 64'({ovf8f, 32'(o8f)}), 64'(q8f[0]));
        if (or8) void'(q8f.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && ov16) begin
      if (q16.size() == 0) begin
        n_checks++;
        $display("FAIL u16 unexpected result: got %0h expected none", o16);
      end else begin
        chk("u16 result", 64'({ovf16, o16}), 64'(q16[0]));
        if (or16) void'(q16.pop_front());
      end
    end
  end

  // ------------------------------------------------------------ drivers
  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input bit sm, input int hold);
    int n;
    logic [7:0] snap;
    logic snap_ovf;
    chk("u8 in_ready idle", 64'(ir8), 64'd1);
    a8 = a; b8 = b; sm8 = sm; iv8 = 1'b1;
    q8.push_back(model(8, 1'b0, {8'd0, a}, {8'd0, b}, sm));
    q8f.push_back(model(8, 1'b1, {8'd0, a}, {8'd0, b}, sm));
    @(posedge clk); #1;
    iv8 = 1'b0;
    n = 0;
    while (!ov8 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("u8 latency", 64'(n), 64'd9);
    chk("u8f valid with u8", 64'(ov8f), 64'd1);
    if (!ov8) begin
      q8.delete();
      q8f.delete();
      return;
    end
    snap = o8;
    snap_ovf = ovf8;
    for (int i = 0; i < hold; i++) begin
      a8 = 8'($urandom_range(0, 255));
      b8 = 8'($urandom_range(0, 255));
      iv8 = 1'b1;
      @(posedge clk); #1;
      chk("bp out stable", 64'({snap_ovf, snap}), 64'({ovf8, o8}));
      chk("bp in_ready low", 64'(ir8), 64'd0);
      chk("bp valid held", 64'(ov8), 64'd1);
    end
    iv8 = 1'b0;
    or8 = 1'b1;
    @(posedge clk); #1;
    or8 = 1'b0;
    chk("ack in_ready", 64'({ir8, ir8f}), 64'b11);
    chk("ack valid low", 64'({ov8, ov8f}), 64'b00);
    if (hold > 0) begin
      @(posedge clk); #1;
      chk("no buffered op", 64'({ov8, ir8, st8}), 64'b0100);
    end
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] b, input bit sm);
    int n;
    chk("u16 in_ready idle", 64'(ir16), 64'd1);
    a16 = a; b16 = b; sm16 = sm; iv16 = 1'b1;
    q16.push_back(model(16, 1'b1, a, b, sm));
    @(posedge clk); #1;
    iv16 = 1'b0;
    n = 0;
    while (!ov16 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    chk("u16 latency", 64'(n), 64'd17);
    if (!ov16) begin
      q16.delete();
      return;
    end
    or16 = 1'b1;
    @(posedge clk); #1;
    or16 = 1'b0;
    chk("u16 ack", 64'({ov16, ir16}), 64'b01);
  endtask

  // ------------------------------------------------------------ stimulus
  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state of every instance
    chk("rst u8",  64'({ir8, ov8, ovf8, o8, st8}), 64'({1'b1, 1'b0, 1'b0, 8'd0, 2'd0}));
    chk("rst u8f", 64'({ir8f, ov8f, ovf8f, o8f, st8f}), 64'({1'b1, 1'b0, 1'b0, 16'd0, 2'd0}));
    chk("rst u16", 64'({ir16, ov16, ovf16, o16, st16}), 64'({1'b1, 1'b0, 1'b0, 32'd0, 2'd0}));

    // Model pinned by hand-computed values
    chk("model 255*255",   64'(model(8, 1'b0, 16'd255, 16'd255, 1'b0)), 64'({1'b1, 32'h01}));
    chk("model -128*-128", 64'(model(8, 1'b1, 16'h80, 16'h80, 1'b1)), 64'({1'b0, 32'h4000}));
    chk("model -3*5",      64'(model(8, 1'b0, 16'hFD, 16'd5, 1'b1)), 64'({1'b0, 32'hF1}));

    // Unsigned max operands
    op8(8'd255, 8'd255, 1'b0, 0);
    chk("255*255 u8",  64'({ovf8, o8}), 64'({1'b1, 8'h01}));
    chk("255*255 u8f", 64'({ovf8f, o8f}), 64'({1'b0, 16'hFE01}));

    // Signed corners
    op8(8'h80, 8'h80, 1'b1, 0);
    chk("-128*-128 u8f", 64'({ovf8f, o8f}), 64'({1'b0, 16'h4000}));
    chk("-128*-128 u8",  64'({ovf8, o8}), 64'({1'b1, 8'h00}));
    op8(8'hFD, 8'd5, 1'b1, 0);
    chk("-3*5 u8",  64'({ovf8, o8}), 64'({1'b0, 8'hF1}));
    chk("-3*5 u8f", 64'({ovf8f, o8f}), 64'({1'b0, 16'hFFF1}));
    op8(8'h80, 8'd1, 1'b1, 0);
    chk("-128*1 u8", 64'({ovf8, o8}), 64'({1'b0, 8'h80}));
    op8(8'd64, 8'd2, 1'b1, 0);
    chk("64*2 signed u8", 64'({ovf8, o8}), 64'({1'b1, 8'h80}));
    op8(8'd0, 8'd0, 1'b0, 0);
    chk("0*0 u8", 64'({ovf8, o8}), 64'({1'b0, 8'h00}));

    // Backpressure with in_valid pressed during DONE
    op8(8'd100, 8'd3, 1'b0, 5);
    chk("100*3 u8", 64'({ovf8, o8}), 64'({1'b1, 8'h2C}));

    // Reset in the middle of RUN
    a8 = 8'd200; b8 = 8'd100; sm8 = 1'b0; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("mid-run state", 64'(st8), 64'd1);
    rst = 1'b1;
    iv8 = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    iv8 = 1'b0;
    chk("mid-run rst u8",  64'({ir8, ov8, ovf8, o8, st8}), 64'({1'b1, 1'b0, 1'b0, 8'd0, 2'd0}));
    chk("mid-run rst u8f", 64'({ir8f, ov8f, o8f}), 64'({1'b1, 1'b0, 16'd0}));
    op8(8'd7, 8'd6, 1'b0, 0);
    chk("7*6 after rst", 64'({ovf8, o8}), 64'({1'b0, 8'd42}));

    // Strided sweep over the 8-bit unsigned space, corners included
    for (int ia = 0; ia <= 255; ia += 17) begin
      for (int ib = 0; ib <= 255; ib += 15) begin
        op8(8'(ia), 8'(ib), 1'b0, 0);
      end
    end

    // 16-bit full product
    op16(16'h8000, 16'h8000, 1'b1);
    chk("-32768^2 u16", 64'({ovf16, o16}), 64'({1'b0, 32'h4000_0000}));
    op16(16'hFFFF, 16'hFFFF, 1'b0);
    chk("65535^2 u16", 64'({ovf16, o16}), 64'({1'b0, 32'hFFFE_0001}));
    op16(16'hFFFF, 16'd2, 1'b1);
    chk("-1*2 u16", 64'({ovf16, o16}), 64'({1'b0, 32'hFFFF_FFFE}));
    for (int i = 0; i < 1000; i++) begin
      op16(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
           1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("queues drained", 64'(q8.size() + q8f.size() + q16.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
